// File: rtl/imem_dmem_arbiter_if.sv
// Fetch, LSU and memory-side signals of imem_dmem_arbiter, bundled as one bus.
// slave is the arbiter's view; master is the view of the surrounding fetch/LSU/memory.
interface imem_dmem_arbiter_if #(
   parameter int ADDR_W = 64
);
   logic              flush_i;

   logic              i_req_i;
   logic [ADDR_W-1:0] i_addr_i;
   logic              i_ready_o;
   logic              i_resp_valid_o;
   logic [31:0]       i_instr_o;
   logic              i_exc_valid_o;
   logic [4:0]        i_exc_code_o;
   logic              i_resp_ready_i;

   logic              d_req_i;
   logic [ADDR_W-1:0] d_addr_i;
   logic              d_we_i;
   logic [63:0]       d_wdata_i;
   logic [7:0]        d_wstrb_i;
   logic              d_ready_o;
   logic              d_resp_valid_o;
   logic [63:0]       d_rdata_o;
   logic              d_exc_valid_o;
   logic [4:0]        d_exc_code_o;
   logic              d_resp_ready_i;

   logic              mem_req_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_we_o;
   logic [63:0]       mem_wdata_o;
   logic [7:0]        mem_wstrb_o;
   logic              mem_req_ready_i;
   logic              mem_resp_valid_i;
   logic [63:0]       mem_rdata_i;
   logic              mem_resp_err_i;
   logic              mem_resp_ready_o;

   modport slave (
      input  flush_i,
      input  i_req_i, i_addr_i, i_resp_ready_i,
      output i_ready_o, i_resp_valid_o, i_instr_o, i_exc_valid_o, i_exc_code_o,
      input  d_req_i, d_addr_i, d_we_i, d_wdata_i, d_wstrb_i, d_resp_ready_i,
      output d_ready_o, d_resp_valid_o, d_rdata_o, d_exc_valid_o, d_exc_code_o,
      output mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_wstrb_o, mem_resp_ready_o,
      input  mem_req_ready_i, mem_resp_valid_i, mem_rdata_i, mem_resp_err_i
   );

   modport master (
      output flush_i,
      output i_req_i, i_addr_i, i_resp_ready_i,
      input  i_ready_o, i_resp_valid_o, i_instr_o, i_exc_valid_o, i_exc_code_o,
      output d_req_i, d_addr_i, d_we_i, d_wdata_i, d_wstrb_i, d_resp_ready_i,
      input  d_ready_o, d_resp_valid_o, d_rdata_o, d_exc_valid_o, d_exc_code_o,
      input  mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_wstrb_o, mem_resp_ready_o,
      output mem_req_ready_i, mem_resp_valid_i, mem_rdata_i, mem_resp_err_i
   );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one in-order memory port between fetch and LSU: one transaction in flight, zero added latency on request and response; memory
// sees the owner's resp_ready as backpressure, squashed fetches drain internally. Define MEM_ARB_RR_EN for round-robin instead of data priority.
module imem_dmem_arbiter #(
   parameter int         ADDR_W        = 64,
   parameter logic [4:0] I_FAULT_CODE  = 5'd1,
   parameter logic [4:0] LD_FAULT_CODE = 5'd5,
   parameter logic [4:0] ST_FAULT_CODE = 5'd7
) (
   input logic               clk,
   input logic               resetn,
   imem_dmem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_ARB_IDLE,
      S_ARB_WAIT_I,
      S_ARB_WAIT_D
   } arb_state_e;

   arb_state_e state_q, state_d;
   logic       squash_q, squash_d;
   logic       addr2_q, addr2_d;
   logic       we_q, we_d;
   logic       d_wins;

`ifdef MEM_ARB_RR_EN
   logic       rr_q, rr_d;
   assign d_wins = rr_q;
`else
   assign d_wins = 1'b1;
`endif

   logic              in_idle, in_wait_i, in_wait_d;
   logic              grant_d, i_hs, d_hs, drop_i, resp_hs;
   logic [ADDR_W-1:0] addr_mux;

   // Folding resetn into the state decode forces every output low during reset.
   assign in_idle   = resetn & (state_q == S_ARB_IDLE);
   assign in_wait_i = resetn & (state_q == S_ARB_WAIT_I);
   assign in_wait_d = resetn & (state_q == S_ARB_WAIT_D);

   assign grant_d = bus.d_req_i & (d_wins | ~bus.i_req_i);

   assign bus.i_ready_o = in_idle & bus.mem_req_ready_i & ~(bus.d_req_i & d_wins);
   assign bus.d_ready_o = in_idle & bus.mem_req_ready_i & ~(bus.i_req_i & ~d_wins);
   assign i_hs          = bus.i_req_i & bus.i_ready_o;
   assign d_hs          = bus.d_req_i & bus.d_ready_o;

   assign addr_mux        = grant_d ? bus.d_addr_i : bus.i_addr_i;
   assign bus.mem_req_o   = in_idle & (bus.i_req_i | bus.d_req_i);
   assign bus.mem_addr_o  = bus.mem_req_o ? addr_mux : '0;
   assign bus.mem_we_o    = bus.mem_req_o & grant_d & bus.d_we_i;
   assign bus.mem_wdata_o = (bus.mem_req_o & grant_d) ? bus.d_wdata_i : 64'd0;
   assign bus.mem_wstrb_o = (bus.mem_req_o & grant_d) ? bus.d_wstrb_i : 8'd0;

   assign drop_i             = squash_q | bus.flush_i;
   assign bus.i_resp_valid_o = in_wait_i & bus.mem_resp_valid_i & ~drop_i;
   assign bus.i_exc_valid_o  = bus.i_resp_valid_o & bus.mem_resp_err_i;
   assign bus.i_exc_code_o   = bus.i_exc_valid_o ? I_FAULT_CODE : 5'd0;
   assign bus.i_instr_o      = (bus.i_resp_valid_o & ~bus.mem_resp_err_i)
                             ? (addr2_q ? bus.mem_rdata_i[63:32] : bus.mem_rdata_i[31:0])
                             : 32'd0;

   assign bus.d_resp_valid_o = in_wait_d & bus.mem_resp_valid_i;
   assign bus.d_exc_valid_o  = bus.d_resp_valid_o & bus.mem_resp_err_i;
   assign bus.d_exc_code_o   = bus.d_exc_valid_o ? (we_q ? ST_FAULT_CODE : LD_FAULT_CODE) : 5'd0;
   assign bus.d_rdata_o      = (bus.d_resp_valid_o & ~bus.mem_resp_err_i) ? bus.mem_rdata_i : 64'd0;

   // A squashed fetch still has to consume its response so the port frees up.
   assign bus.mem_resp_ready_o = (in_wait_i & (drop_i | bus.i_resp_ready_i))
                               | (in_wait_d & bus.d_resp_ready_i);
   assign resp_hs = bus.mem_resp_valid_i & bus.mem_resp_ready_o;

   always_comb begin
      state_d  = state_q;
      squash_d = squash_q;
      addr2_d  = addr2_q;
      we_d     = we_q;
`ifdef MEM_ARB_RR_EN
      rr_d     = rr_q;
`endif
      case (state_q)
         S_ARB_IDLE: begin
            if (d_hs) begin
               state_d = S_ARB_WAIT_D;
               addr2_d = bus.d_addr_i[2];
               we_d    = bus.d_we_i;
`ifdef MEM_ARB_RR_EN
               rr_d    = 1'b0;
`endif
            end else if (i_hs) begin
               state_d = S_ARB_WAIT_I;
               addr2_d = bus.i_addr_i[2];
               we_d    = 1'b0;
`ifdef MEM_ARB_RR_EN
               rr_d    = 1'b1;
`endif
            end
         end
         S_ARB_WAIT_I: begin
            if (resp_hs) begin
               state_d  = S_ARB_IDLE;
               squash_d = 1'b0;
            end else if (bus.flush_i) begin
               squash_d = 1'b1;
            end
         end
         S_ARB_WAIT_D: begin
            if (resp_hs) state_d = S_ARB_IDLE;
         end
         default: state_d = S_ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= S_ARB_IDLE;
         squash_q <= 1'b0;
         addr2_q  <= 1'b0;
         we_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
         rr_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         squash_q <= squash_d;
         addr2_q  <= addr2_d;
         we_q     <= we_d;
`ifdef MEM_ARB_RR_EN
         rr_q     <= rr_d;
`endif
      end
   end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed and randomized transactions through imem_dmem_arbiter against a transaction-level model of
// arbitration priority, response ownership, squashing and fault codes.
module tb_imem_dmem_arbiter;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   imem_dmem_arbiter_if #(.ADDR_W(64)) bus ();

   imem_dmem_arbiter dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   bit rr_model = 1'b0;   // 1 = data port holds the tie-break

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_inputs();
      bus.flush_i          = 1'b0;
      bus.i_req_i          = 1'b0;
      bus.i_addr_i         = '0;
      bus.i_resp_ready_i   = 1'b0;
      bus.d_req_i          = 1'b0;
      bus.d_addr_i         = '0;
      bus.d_we_i           = 1'b0;
      bus.d_wdata_i        = '0;
      bus.d_wstrb_i        = '0;
      bus.d_resp_ready_i   = 1'b0;
      bus.mem_req_ready_i  = 1'b1;
      bus.mem_resp_valid_i = 1'b0;
      bus.mem_rdata_i      = '0;
      bus.mem_resp_err_i   = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, {bus.i_ready_o, bus.i_resp_valid_o, bus.i_instr_o, bus.i_exc_valid_o,
                          bus.i_exc_code_o, bus.d_ready_o, bus.d_resp_valid_o, bus.d_exc_valid_o,
                          bus.d_exc_code_o, bus.mem_req_o, bus.mem_we_o, bus.mem_wstrb_o,
                          bus.mem_resp_ready_o}, 64'd0);
      chk({tag, "_bus"}, bus.d_rdata_o | bus.mem_addr_o | bus.mem_wdata_o, 64'd0);
   endtask

   // One complete transaction: issue, lat idle cycles, response held for stall cycles.
   // fmode: 0 no flush, 1 flush pulse in the cycle before the response, 2 flush with the response.
   task automatic txn(input bit ir, input logic [63:0] ia, input bit dr, input logic [63:0] da,
                      input bit dwe, input logic [63:0] wd, input logic [7:0] ws, input int lat,
                      input logic [63:0] rd, input bit err, input int fmode_in, input int stall_in);
      bit prio_d, win_d, sq, rdy;
      int fmode, stall;
      logic [31:0] word;
      fmode  = (fmode_in == 1 && lat == 0) ? 2 : fmode_in;
      prio_d = RR ? rr_model : 1'b1;
      win_d  = dr && (!ir || prio_d);
      sq     = !win_d && (fmode != 0);
      stall  = sq ? 0 : stall_in;
      word   = ia[2] ? rd[63:32] : rd[31:0];

      bus.i_req_i = ir;  bus.i_addr_i = ia;
      bus.d_req_i = dr;  bus.d_addr_i = da;  bus.d_we_i = dwe;
      bus.d_wdata_i = wd; bus.d_wstrb_i = ws;
      bus.mem_req_ready_i = 1'b1;
      @(negedge clk);
      chk("issue_i_ready", bus.i_ready_o, !(dr && prio_d));
      chk("issue_d_ready", bus.d_ready_o, !(ir && !prio_d));
      chk("issue_mem_req", bus.mem_req_o, 1'b1);
      chk("issue_addr", bus.mem_addr_o, win_d ? da : ia);
      chk("issue_we", bus.mem_we_o, win_d && dwe);
      chk("issue_wstrb", bus.mem_wstrb_o, win_d ? ws : 8'h00);
      if (win_d) chk("issue_wdata", bus.mem_wdata_o, wd);
      rr_model = !win_d;
      tick();

      // Both requesters keep asking: nothing may be granted while one is outstanding.
      bus.i_req_i = 1'b1;
      bus.d_req_i = 1'b1;
      for (int k = 0; k < lat; k++) begin
         bus.flush_i = (fmode == 1 && k == lat - 1);
         @(negedge clk);
         chk("wait_mem_req", bus.mem_req_o, 1'b0);
         chk("wait_readies", {bus.i_ready_o, bus.d_ready_o}, 2'b00);
         chk("wait_resp_valid", {bus.i_resp_valid_o, bus.d_resp_valid_o}, 2'b00);
         tick();
      end

      bus.i_req_i = 1'b0;
      bus.d_req_i = 1'b0;
      bus.flush_i = (fmode == 2);
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_rdata_i = rd;
      bus.mem_resp_err_i = err;
      for (int k = 0; k <= stall; k++) begin
         rdy = (k == stall);
         bus.i_resp_ready_i = win_d ? 1'b1 : rdy;
         bus.d_resp_ready_i = win_d ? rdy : 1'b1;
         @(negedge clk);
         if (win_d) begin
            chk("d_resp_valid", bus.d_resp_valid_o, 1'b1);
            chk("d_exc_valid", bus.d_exc_valid_o, err);
            chk("d_rdata", bus.d_rdata_o, err ? 64'd0 : rd);
            if (err) chk("d_exc_code", bus.d_exc_code_o, dwe ? 5'd7 : 5'd5);
            chk("d_other_valid", bus.i_resp_valid_o, 1'b0);
            chk("d_mem_resp_ready", bus.mem_resp_ready_o, rdy);
         end else begin
            chk("i_resp_valid", bus.i_resp_valid_o, !sq);
            chk("i_exc_valid", bus.i_exc_valid_o, err && !sq);
            if (!sq) chk("i_instr", bus.i_instr_o, err ? 32'd0 : word);
            if (err && !sq) chk("i_exc_code", bus.i_exc_code_o, 5'd1);
            chk("i_other_valid", bus.d_resp_valid_o, 1'b0);
            chk("i_mem_resp_ready", bus.mem_resp_ready_o, sq ? 1'b1 : rdy);
         end
         tick();
      end

      bus.mem_resp_valid_i = 1'b0;
      bus.mem_resp_err_i = 1'b0;
      bus.flush_i = 1'b0;
      bus.i_resp_ready_i = 1'b0;
      bus.d_resp_ready_i = 1'b0;
      @(negedge clk);
      chk("back_idle", {bus.i_ready_o, bus.d_ready_o, bus.i_resp_valid_o, bus.d_resp_valid_o}, 4'b1100);
      tick();
   endtask

   initial begin
      bit ir, dr, dwe, err;
      int fm;
      logic [63:0] ia, da;

      // Reset with every input active.
      quiet_inputs();
      bus.i_req_i = 1'b1; bus.d_req_i = 1'b1; bus.mem_resp_valid_i = 1'b1;
      bus.i_resp_ready_i = 1'b1; bus.d_resp_ready_i = 1'b1; bus.flush_i = 1'b1;
      resetn = 1'b0;
      @(negedge clk);
      chk_all_zero("reset");
      tick();
      tick();
      quiet_inputs();
      resetn = 1'b1;
      bus.mem_req_ready_i = 1'b0;
      @(negedge clk);
      chk("i_ready_follows_0", bus.i_ready_o, 1'b0);
      bus.mem_req_ready_i = 1'b1;
      #1;
      chk("i_ready_follows_1", bus.i_ready_o, 1'b1);
      tick();

      // Four ties straight after reset: D,D,D,D with fixed priority, I,D,I,D with round-robin.
      for (int t = 0; t < 4; t++)
         txn(1'b1, 64'h8000_0000 + 64'(t * 4), 1'b1, 64'h8000_1000, 1'b1,
             64'hDEAD_BEEF_0123_4567 + 64'(t), 8'hFF, 1, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 0, 0);

      // Fetch of the upper word with a 3-cycle memory.
      txn(1'b1, 64'h8000_0004, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00, 3, 64'h1111_1111_2222_2222, 1'b0, 0, 0);
      // Lower word.
      txn(1'b1, 64'h8000_0010, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00, 0, 64'h1111_1111_2222_2222, 1'b0, 0, 0);
      // Flush one cycle ahead of the response, then an ordinary fetch is accepted.
      txn(1'b1, 64'h8000_0020, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00, 2, 64'hCAFE_0000_BEEF_0000, 1'b0, 1, 0);
      txn(1'b1, 64'h8000_0024, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00, 0, 64'h1234_5678_9ABC_DEF0, 1'b0, 0, 0);
      // Flush coinciding with the response.
      txn(1'b1, 64'h8000_0028, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00, 0, 64'h1234_5678_9ABC_DEF0, 1'b0, 2, 0);
      // Load and store faults, then an instruction fault.
      txn(1'b0, 64'd0, 1'b1, 64'h8000_2000, 1'b0, 64'd0, 8'h00, 1, 64'h7777_7777_7777_7777, 1'b1, 0, 0);
      txn(1'b0, 64'd0, 1'b1, 64'h8000_2008, 1'b1, 64'h55, 8'h0F, 1, 64'h7777_7777_7777_7777, 1'b1, 0, 0);
      txn(1'b1, 64'h8000_0030, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00, 1, 64'h9999_9999_8888_8888, 1'b1, 0, 0);
      // LSU holds off the response for 4 cycles.
      txn(1'b0, 64'd0, 1'b1, 64'h8000_3000, 1'b0, 64'd0, 8'h00, 1, 64'h0102_0304_0506_0708, 1'b0, 0, 4);
      // Flush during a data transaction changes nothing.
      txn(1'b0, 64'd0, 1'b1, 64'h8000_3008, 1'b0, 64'd0, 8'h00, 2, 64'h0BAD_F00D_0BAD_F00D, 1'b0, 1, 0);
      txn(1'b0, 64'd0, 1'b1, 64'h8000_3010, 1'b0, 64'd0, 8'h00, 0, 64'h0BAD_F00D_0BAD_F00D, 1'b0, 2, 0);

      // Reset while a data transaction is outstanding.
      bus.d_req_i = 1'b1; bus.d_addr_i = 64'h8000_4000; bus.d_we_i = 1'b0;
      tick();
      bus.d_req_i = 1'b1; bus.i_req_i = 1'b1;
      bus.mem_resp_valid_i = 1'b1; bus.mem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.d_resp_ready_i = 1'b1;
      resetn = 1'b0;
      @(negedge clk);
      chk_all_zero("reset_mid_0");
      tick();
      @(negedge clk);
      chk_all_zero("reset_mid_1");
      tick();
      quiet_inputs();
      resetn = 1'b1;
      rr_model = 1'b0;
      bus.mem_req_ready_i = 1'b0;
      @(negedge clk);
      chk("post_reset_ready_0", bus.i_ready_o, 1'b0);
      chk("post_reset_no_resp", bus.d_resp_valid_o, 1'b0);
      bus.mem_req_ready_i = 1'b1;
      #1;
      chk("post_reset_ready_1", bus.i_ready_o, 1'b1);
      tick();
      // Tie-break pointer restarts in favour of fetch.
      txn(1'b1, 64'h8000_0040, 1'b1, 64'h8000_5000, 1'b1, 64'h1, 8'h01, 0, 64'h2468_ACE0_1357_9BDF, 1'b0, 0, 0);

      // Random traffic.
      for (int n = 0; n < 80; n++) begin
         ir  = 1'($urandom_range(0, 1));
         dr  = ir ? 1'($urandom_range(0, 1)) : 1'b1;
         dwe = 1'($urandom_range(0, 1));
         err = ($urandom_range(0, 3) == 0);
         fm  = int'($urandom_range(0, 5));
         ia  = {$urandom, $urandom} & ~64'h3;
         da  = {$urandom, $urandom};
         txn(ir, ia, dr, da, dwe, {$urandom, $urandom}, 8'($urandom_range(0, 255)),
             int'($urandom_range(0, 3)), {$urandom, $urandom}, err, (fm > 2) ? 0 : fm,
             int'($urandom_range(0, 2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_dmem_arbiter.md
# imem_dmem_arbiter

Shares a single in-order memory port between the fetch stage's instruction-memory interface and the load/store unit's data-memory interface. Only one transaction is in flight at a time. Each response is routed back to the requester that owns it. Instruction responses are squashed on pipeline flush, while data transactions always run to completion. Sits between `fetch`/LSU and the unified memory/bus adapter.

## Interface
- `ADDR_W`, 64, request address width
- `I_FAULT_CODE`, 5'd1, exc code for instruction access fault
- `LD_FAULT_CODE`, 5'd5, exc code for load access fault
- `ST_FAULT_CODE`, 5'd7, exc code for store access fault

Ports:
- `clk` in 1: clock
- `resetn` in 1: synchronous, active-low reset (one clock; reset is synchronous and active-low)
- `flush_i` in 1: pipeline flush; squashes instruction traffic
- `i_req_i` in 1: fetch request valid
- `i_addr_i` in ADDR_W: fetch address (word aligned)
- `i_ready_o` out 1: fetch request accepted
- `i_resp_valid_o` out 1: instruction valid
- `i_instr_o` out 32: instruction word
- `i_exc_valid_o` out 1: instruction fault
- `i_exc_code_o` out 5: fault code
- `i_resp_ready_i` in 1: fetch accepts response
- `d_req_i` in 1: LSU request valid
- `d_addr_i` in ADDR_W: data address
- `d_we_i` in 1: 1 = store
- `d_wdata_i` in 64: store data
- `d_wstrb_i` in 8: byte strobes
- `d_ready_o` out 1: LSU request accepted
- `d_resp_valid_o` out 1: data response valid
- `d_rdata_o` out 64: load data
- `d_exc_valid_o` out 1: data fault
- `d_exc_code_o` out 5: fault code
- `d_resp_ready_i` in 1: LSU accepts response
- `mem_req_o` out 1: memory request valid
- `mem_addr_o` out ADDR_W, `mem_we_o` out 1, `mem_wdata_o` out 64, `mem_wstrb_o` out 8: memory request fields
- `mem_req_ready_i` in 1: memory accepts request
- `mem_resp_valid_i` in 1: memory response valid
- `mem_rdata_i` in 64: memory read data
- `mem_resp_err_i` in 1: memory access error
- `mem_resp_ready_o` out 1: arbiter accepts response

## Operation
- **States**
  - `S_ARB_IDLE`: no transaction in flight.
  - `S_ARB_WAIT_I`: instruction transaction outstanding.
  - `S_ARB_WAIT_D`: data transaction outstanding.
- **Grant in `S_ARB_IDLE`**
  - `i_ready_o = mem_req_ready_i & ~(d_req_i & d_wins)`.
  - `d_ready_o = mem_req_ready_i & ~(i_req_i & ~d_wins)`.
  - `d_wins` is the priority select. Fixed data priority by default; see Configuration.
  - `i_ready_o` must never depend on `i_req_i`, because fetch derives its request from the ready.
  - `d_req_i` must not depend on `d_ready_o`.
- **Issue**
  - The granted port's fields pass combinationally to `mem_*`.
  - Instruction requests drive `mem_we_o = 0` and `mem_wstrb_o = 0`.
  - `mem_req_o` is asserted only in `S_ARB_IDLE` with a valid request.
  - A handshake moves the FSM to the matching WAIT state and latches `addr[2]` and `we`.
- **Response routing**
  - `S_ARB_WAIT_I`: `i_instr_o = addr2_ff ? mem_rdata_i[63:32] : mem_rdata_i[31:0]`.
  - `S_ARB_WAIT_D`: `d_rdata_o = mem_rdata_i`.
  - Valid is `mem_resp_valid_i`, routed to the owner only.
  - `mem_resp_ready_o` = the owner's `*_resp_ready_i`.
  - The FSM returns to `S_ARB_IDLE` on the response handshake.
- **Errors**
  - `mem_resp_err_i` asserts the owner's `*_exc_valid_o` alongside its resp_valid.
  - Exc code is `I_FAULT_CODE` for instructions, otherwise `ST_FAULT_CODE` if `we_ff`, else `LD_FAULT_CODE`.
  - Data/instr outputs read 0 while an error is reported.
- **Flush**
  - `flush_i` in `S_ARB_WAIT_I` sets `squash_ff`.
  - While `squash_ff | flush_i`: `i_resp_valid_o = 0`, `i_exc_valid_o = 0`, `mem_resp_ready_o = 1`. The response is drained internally and the FSM returns to IDLE.
  - `squash_ff` clears on the return to IDLE.
  - Flush has no effect on data transactions or in IDLE.
- **Reset**
  - Synchronous; `resetn` is sampled on `clk` rising edge.
  - While `resetn = 0`, every output is 0, including the readies.
  - After reset: `S_ARB_IDLE`, `squash_ff = 0`, `addr2_ff = 0`, `we_ff = 0`, RR pointer favours instruction.
  - Reset mid-transaction abandons it; memory is reset in the same domain.

## Timing
- Request path is combinational: port handshake and `mem_req_o` occur in the same cycle.
- Response path is combinational from `mem_resp_*` to the owner port (zero added latency).
- At most one outstanding request.
- Earliest next grant is the cycle after the response handshake. For a 1-cycle memory, throughput is 1 request per 2 cycles.
- A simultaneous flush and response in `S_ARB_WAIT_I` drops the response in that same cycle.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - `d_wins` = RR pointer.
  - The pointer flips to the other port after each granted request, so a port that just won loses the next tie.
- `MEM_ARB_RR_EN` undefined: fixed priority, `d_wins = 1`.
  - Data always wins ties; fetch can starve while the LSU streams.

## Test plan
- Fetch `i_addr_i = 0x8000_0004`, memory returns `mem_rdata_i = 0x11111111_22222222` after 3 cycles -> `i_instr_o = 0x11111111`, `i_resp_valid_o` for 1 cycle, `d_resp_valid_o` stays 0.
- `i_req_i` and `d_req_i` (store to `0x8000_1000`, wstrb `0xFF`) are high in the same cycle.
  - Without RR: data is granted first, `mem_we_o = 1`.
  - With `MEM_ARB_RR_EN`: grants after reset are I, D, I, D.
- Fetch outstanding, `flush_i` pulses 1 cycle before `mem_resp_valid_i` -> no `i_resp_valid_o`, `mem_resp_ready_o = 1`, FSM back in IDLE, next fetch accepted.
- Load with `mem_resp_err_i = 1` -> `d_exc_valid_o = 1`, `d_exc_code_o = 5'd5`; the same as a store gives `5'd7`.
- Response valid with `d_resp_ready_i = 0` for 4 cycles -> response held stable, `mem_resp_ready_o = 0`, no new grant until the handshake.
- `resetn` driven low while in `S_ARB_WAIT_D` -> next cycle all outputs 0; after release, FSM is IDLE and `i_ready_o` follows `mem_req_ready_i`.
